// File: rtl/vga_timing_gen.sv
// rtl/vga_timing_gen.sv - parametrised VGA timing generator
// Counters, sync/blank strobes, frame-start pulse and frame counter, all registered.
module vga_timing_gen #(
  parameter int CNT_W        = 11,
  parameter int H_ACTIVE     = 1024,
  parameter int H_SYNC_START = 1048,
  parameter int H_SYNC_END   = 1184,
  parameter int H_TOTAL      = 1344,
  parameter int V_ACTIVE     = 768,
  parameter int V_SYNC_START = 771,
  parameter int V_SYNC_END   = 777,
  parameter int V_TOTAL      = 806,
  parameter bit HSYNC_POL    = 1'b1,
  parameter bit VSYNC_POL    = 1'b1,
  parameter int FRAME_W      = 16
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               en,
  output logic [CNT_W-1:0]   hcount,
  output logic [CNT_W-1:0]   vcount,
  output logic               hsync,
  output logic               vsync,
  output logic               hblnk,
  output logic               vblnk,
  output logic               frame_start,
  output logic [FRAME_W-1:0] frame_cnt
);

  // Decode compares use one extra bit so a SYNC_END equal to 2^CNT_W stays representable.
  localparam int XW = CNT_W + 1;
  localparam logic [XW-1:0]    H_ACT_X = XW'(H_ACTIVE);
  localparam logic [XW-1:0]    H_SS_X  = XW'(H_SYNC_START);
  localparam logic [XW-1:0]    H_SE_X  = XW'(H_SYNC_END);
  localparam logic [XW-1:0]    V_ACT_X = XW'(V_ACTIVE);
  localparam logic [XW-1:0]    V_SS_X  = XW'(V_SYNC_START);
  localparam logic [XW-1:0]    V_SE_X  = XW'(V_SYNC_END);
  localparam logic [CNT_W-1:0] H_LAST  = CNT_W'(H_TOTAL - 1);
  localparam logic [CNT_W-1:0] V_LAST  = CNT_W'(V_TOTAL - 1);

  generate
    if (!(H_ACTIVE < H_SYNC_START && H_SYNC_START < H_SYNC_END && H_SYNC_END <= H_TOTAL))
    begin : g_bad_h_timing
      $fatal(1, "vga_timing_gen: illegal horizontal timing parameters");
    end
    if (!(V_ACTIVE < V_SYNC_START && V_SYNC_START < V_SYNC_END && V_SYNC_END <= V_TOTAL))
    begin : g_bad_v_timing
      $fatal(1, "vga_timing_gen: illegal vertical timing parameters");
    end
    if (H_TOTAL > (1 << CNT_W) || V_TOTAL > (1 << CNT_W)) begin : g_bad_cnt_w
      $fatal(1, "vga_timing_gen: CNT_W too narrow for H_TOTAL/V_TOTAL");
    end
  endgenerate

  logic             h_wrap;
  logic             v_wrap;
  logic [CNT_W-1:0] hcount_nxt;
  logic [CNT_W-1:0] vcount_nxt;
  logic [XW-1:0]    h_x;
  logic [XW-1:0]    v_x;

  always_comb begin
    h_wrap     = (hcount == H_LAST);
    v_wrap     = (vcount == V_LAST);
    hcount_nxt = h_wrap ? '0 : hcount + 1'b1;
    vcount_nxt = vcount;
    if (h_wrap) begin
      vcount_nxt = v_wrap ? '0 : vcount + 1'b1;
    end
    h_x = {1'b0, hcount_nxt};
    v_x = {1'b0, vcount_nxt};
  end

  // Strobes decode the next counter values so they line up with hcount/vcount.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hcount      <= '0;
      vcount      <= '0;
      hsync       <= ~HSYNC_POL;
      vsync       <= ~VSYNC_POL;
      hblnk       <= 1'b0;
      vblnk       <= 1'b0;
      frame_start <= 1'b0;
      frame_cnt   <= '0;
    end else if (en) begin
      hcount      <= hcount_nxt;
      vcount      <= vcount_nxt;
      hsync       <= ((h_x >= H_SS_X) && (h_x < H_SE_X)) ? HSYNC_POL : ~HSYNC_POL;
      vsync       <= ((v_x >= V_SS_X) && (v_x < V_SE_X)) ? VSYNC_POL : ~VSYNC_POL;
      hblnk       <= (h_x >= H_ACT_X);
      vblnk       <= (v_x >= V_ACT_X);
      frame_start <= h_wrap & v_wrap;
      frame_cnt   <= frame_cnt + FRAME_W'(h_wrap & v_wrap);
    end else begin
      frame_start <= 1'b0;
    end
  end

endmodule
